ram_burst_reader: RTL

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader_pkg.sv | 13 +
 rtl/ram_sp_1r1w.sv | 30 +++
 rtl/ram_burst_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the burst reader: default widths and the FSM state encoding.
package ram_burst_reader_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/ram_sp_1r1w.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port,
// 1-cycle read latency, read-before-write on an address collision.
module ram_sp_1r1w
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Storage is never reset; non-blocking update yields the old word on collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive RAM words (wrapping address) and streams them
// out over a valid/ready handshake, optionally byte-swapped.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic              swap,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              swap_r;

  logic              hs_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] word_s;

  ram_sp_1r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en_s),
    .rd_addr(rd_addr_s),
    .rd_data(rd_data_s)
  );

  // Read issue: first word on start, next word on a non-final handshake.
  always_comb begin
    hs_s      = out_valid && out_ready;
    rd_en_s   = 1'b0;
    rd_addr_s = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (start && rst_n) begin
          rd_en_s   = 1'b1;
          rd_addr_s = base;
        end else begin
          rd_en_s   = 1'b0;
        end
      end
      ST_HOLD: begin
        if (hs_s && (cnt_r != '0) && rst_n) begin
          rd_en_s   = 1'b1;
          rd_addr_s = addr_r + ADDR_W'(1);
        end else begin
          rd_en_s   = 1'b0;
        end
      end
      default: begin
        rd_en_s   = 1'b0;
      end
    endcase
  end

  // Optional byte exchange of the word coming out of the RAM.
  always_comb begin
    if (swap_r) begin
      word_s = {rd_data_s[DATA_W/2-1:0], rd_data_s[DATA_W-1:DATA_W/2]};
    end else begin
      word_s = rd_data_s;
    end
  end

  // Burst control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      cnt_r     <= '0;
      swap_r    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            addr_r  <= base;
            cnt_r   <= len;
            swap_r  <= swap;
            busy    <= 1'b1;
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          out_valid <= 1'b1;
          out_data  <= word_s;
          out_last  <= (cnt_r == '0);
          state_r   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hs_s) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (cnt_r != '0) begin
              addr_r  <= addr_r + ADDR_W'(1);
              cnt_r   <= cnt_r - ADDR_W'(1);
              state_r <= ST_READ;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
